bram_be: RTL and testbench
==========================

# bram_be

Parametrised successor to the core's single-port byte BRAM. It is a simple dual-port, word-wide block RAM: port A reads and writes with per-lane byte enables, and port B is read-only. A selectable read-during-write mode and a post-reset clear sequencer replace simulation-only `initial` zeroing. It sits between the CPU load/store unit (port A) and the instruction fetch path (port B), giving fetch and data access one synchronous cycle each.

## Interface
- `LANES`, 4: byte lanes per word.
- `LANE_WIDTH`, 8: bits per lane; word width W = `LANES*LANE_WIDTH`.
- `ADDR_WIDTH`, 10: word-address width; DEPTH = 2^`ADDR_WIDTH`.
- `RDW_MODE`, 0: port A read-during-write behaviour: 0 = NO_CHANGE, 1 = READ_FIRST, 2 = WRITE_FIRST.
- `CLEAR_ON_RESET`, 1: 1 = zero every word after reset; 0 = skip the clear.
- `i_clk`  in  1  sole clock, rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_a_req`  in  1  port A request strobe.
- `i_a_write`  in  1  1 = write, 0 = read.
- `i_a_be`  in  `LANES`  lane write enables; ignored on reads.
- `i_a_addr`  in  `ADDR_WIDTH`  port A word address.
- `i_a_data`  in  W  port A write data.
- `o_a_data`  out  W  port A read data.
- `o_a_valid`  out  1  one-cycle pulse per accepted A request.
- `i_b_req`  in  1  port B read strobe.
- `i_b_addr`  in  `ADDR_WIDTH`  port B word address.
- `o_b_data`  out  W  port B read data.
- `o_b_valid`  out  1  one-cycle pulse per accepted B request.
- `o_busy`  out  1  clear sequence in progress; requests are not accepted.

## Operation
- FSM states:
  - CLEAR: writes zero to `clr_addr`, increments `clr_addr`; at `clr_addr == DEPTH-1` it writes the last word and moves to READY.
  - READY: services requests.
- Reset with `i_rst_n = 0` at an edge:
  - FSM goes to CLEAR if `CLEAR_ON_RESET`, else to READY.
  - `clr_addr` = 0.
  - `o_a_data`, `o_b_data`, `o_a_valid`, `o_b_valid` = 0.
  - `o_busy` = `CLEAR_ON_RESET`.
- Reset asserted mid-clear restarts the clear from address 0.
- While `o_busy` is high:
  - `i_a_req` and `i_b_req` are dropped silently; no valid pulse, no memory change.
  - `o_busy` is a registered output driven from the FSM state.
- Port A write:
  - Each lane k with `i_a_be[k] = 1` is replaced by `i_a_data` lane k; other lanes keep their contents.
  - `i_a_be = 0` is an accepted no-op write; it still pulses `o_a_valid`.
- Port A `o_a_data` after a write:
  - NO_CHANGE: holds its previous value.
  - READ_FIRST: the pre-write word.
  - WRITE_FIRST: the merged post-write word.
- Port A read: `o_a_data` = mem[addr].
- Port B read: `o_b_data` = mem[addr].
- Cross-port collision (B reads the address A writes in the same cycle): B returns the pre-write word in every mode.
- Output hold: `o_a_data` and `o_b_data` hold their value until the next accepted read, or the next accepted write in modes 1 and 2.
- Addresses are word-granular; the address does not wrap or truncate beyond `ADDR_WIDTH`.

## Timing
- Request sampled at edge N; data and valid are presented after edge N and valid during cycle N+1. Read latency is 1.
- Valid is a single-cycle pulse. Back-to-back requests every cycle give back-to-back valid pulses. Both ports are fully independent and concurrent.
- A write at edge N is visible to any read (A or B) sampled at edge N+1 or later.
- Clear duration with `CLEAR_ON_RESET = 1`:
  - DEPTH cycles, counted from the first edge with `i_rst_n = 1`.
  - `o_busy` falls after edge DEPTH.
  - The first request accepted is the one sampled at edge DEPTH+1.
- With `CLEAR_ON_RESET = 0`: requests are accepted from the first edge with `i_rst_n = 1`; memory contents are undefined.
- No combinational path from any input to any output.

## Test plan
Configuration for all scenarios: `ADDR_WIDTH = 4`, `LANES = 4`.
- **Post-reset clear:** preload garbage, hold reset 3 cycles, release → `o_busy` high for exactly 16 cycles; B reads of all 16 addresses then return 0; a request issued during busy produces no valid.
- **Byte-enable merge:** A write 0x11223344 to addr 5 with be=1111, then 0xAABBCCDD with be=0101 → A read of addr 5 returns 0x11BB33DD one cycle later, with one `o_a_valid` pulse per request.
- **Read-during-write modes:** addr 2 holds 0x0000FFFF; A write 0x12345678, be=1100; prior `o_a_data` = 0xCAFEBABE →
  - mode 0: `o_a_data` stays 0xCAFEBABE.
  - mode 1: `o_a_data` = 0x0000FFFF.
  - mode 2: `o_a_data` = 0x1234FFFF.
- **Cross-port collision:** same cycle, A writes 0xDEADBEEF to addr 7 (old 0x00000001) and B reads addr 7 → B returns 0x00000001; a B read on the next cycle returns 0xDEADBEEF.
- **Reset mid-clear:** assert reset at clear cycle 9 for 1 cycle → clear restarts at 0; `o_busy` stays high 16 more cycles; outputs are 0 during reset.
- **Back-to-back throughput:** 16 consecutive B reads interleaved with A writes to disjoint addresses → 16 contiguous `o_b_valid` pulses with data in order and no stalls.

Source files
------------

// File: rtl/bram_be.sv
`timescale 1ns/1ps
// bram_be: simple dual-port, word-wide block RAM with per-lane byte enables.
//
// Port A (load/store unit) reads and writes, with a per-lane byte enable.
// Port B (instruction fetch) is read-only. Both ports have one cycle of
// read latency and can run every cycle at the same time.
// After reset, an optional sequencer writes zero to every word. Requests
// are ignored while it runs.
//
// Parameters
//   LANES          byte lanes per word
//   LANE_WIDTH     bits per lane (word width W = LANES*LANE_WIDTH)
//   ADDR_WIDTH     word address width (DEPTH = 2**ADDR_WIDTH)
//   RDW_MODE       what o_a_data shows after a port A write:
//                  0 no change, 1 read first, 2 write first
//   CLEAR_ON_RESET 1 = zero every word after reset
//
// Ports
//   i_clk                 clock, rising edge
//   i_rst_n               synchronous active-low reset
//   i_a_req/i_a_write     port A strobe / write select
//   i_a_be                port A lane write enables
//   i_a_addr/i_a_data     port A word address / write data
//   o_a_data/o_a_valid    port A read data / one-cycle response pulse
//   i_b_req/i_b_addr      port B read strobe / word address
//   o_b_data/o_b_valid    port B read data / one-cycle response pulse
//   o_busy                clear in progress; requests are dropped
module bram_be #(
    parameter int LANES          = 4,
    parameter int LANE_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_a_req,
    input  logic                          i_a_write,
    input  logic [LANES-1:0]              i_a_be,
    input  logic [ADDR_WIDTH-1:0]         i_a_addr,
    input  logic [LANES*LANE_WIDTH-1:0]   i_a_data,
    output logic [LANES*LANE_WIDTH-1:0]   o_a_data,
    output logic                          o_a_valid,
    input  logic                          i_b_req,
    input  logic [ADDR_WIDTH-1:0]         i_b_addr,
    output logic [LANES*LANE_WIDTH-1:0]   o_b_data,
    output logic                          o_b_valid,
    output logic                          o_busy
);

    localparam int  W           = LANES * LANE_WIDTH;
    localparam int  DEPTH       = 2 ** ADDR_WIDTH;
    localparam bit  HAS_CLEAR   = (CLEAR_ON_RESET != 0);
    localparam bit  WRITE_FIRST = (RDW_MODE == 2);
    localparam bit  NO_CHANGE   = (RDW_MODE == 0);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = HAS_CLEAR ? ST_CLEAR : ST_READY;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   clr_addr_reg, clr_addr_next;
    logic                    busy_reg;
    logic                    a_valid_reg, b_valid_reg;
    logic                    clear_we;
    logic                    a_acc, a_wr_acc, a_upd, b_acc;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [W-1:0]            a_data_word, b_data_word;

    // ------------------------------------------------------------------
    // Clear sequencer / request gate
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        clear_we      = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                clear_we      = i_rst_n;
                clr_addr_next = clr_addr_reg + 1'b1;
                if (clr_addr_reg == {ADDR_WIDTH{1'b1}}) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                state_next = ST_READY;
            end
            default: begin
                state_next = ST_READY;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg    <= RST_STATE;
            clr_addr_reg <= '0;
            busy_reg     <= HAS_CLEAR;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
            // Busy is registered from the next state so it falls in the
            // same cycle the FSM reaches READY.
            busy_reg     <= (state_next == ST_CLEAR);
        end
    end

    assign a_acc    = i_a_req && i_rst_n && (state_reg == ST_READY);
    assign b_acc    = i_b_req && i_rst_n && (state_reg == ST_READY);
    assign a_wr_acc = a_acc && i_a_write;
    // In no-change mode a write leaves o_a_data alone.
    assign a_upd    = a_acc && !(i_a_write && NO_CHANGE);
    // Clear and port A writes never coincide, because port A is only
    // accepted in READY.
    assign wr_addr  = clear_we ? clr_addr_reg : i_a_addr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a_valid_reg <= 1'b0;
            b_valid_reg <= 1'b0;
        end else begin
            a_valid_reg <= a_acc;
            b_valid_reg <= b_acc;
        end
    end

    // ------------------------------------------------------------------
    // One narrow RAM per byte lane, so each lane has its own write enable.
    // Reads are registered and see the pre-write contents. That gives
    // read-first on port A and pre-write data on a B collision.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_WIDTH-1:0] lane_mem [DEPTH];
            logic                  lane_we;
            logic [LANE_WIDTH-1:0] lane_wdata;
            logic [LANE_WIDTH-1:0] a_lane_reg, b_lane_reg;

            assign lane_we    = clear_we || (a_wr_acc && i_a_be[gi]);
            assign lane_wdata = clear_we ? '0
                                         : i_a_data[gi*LANE_WIDTH +: LANE_WIDTH];

            always_ff @(posedge i_clk) begin
                if (lane_we) begin
                    lane_mem[wr_addr] <= lane_wdata;
                end
            end

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    a_lane_reg <= '0;
                    b_lane_reg <= '0;
                end else begin
                    if (a_upd) begin
                        // In write-first mode, enabled lanes show the new
                        // data. Every other case shows the stored word.
                        if (WRITE_FIRST && a_wr_acc && i_a_be[gi]) begin
                            a_lane_reg <= i_a_data[gi*LANE_WIDTH +: LANE_WIDTH];
                        end else begin
                            a_lane_reg <= lane_mem[i_a_addr];
                        end
                    end
                    if (b_acc) begin
                        b_lane_reg <= lane_mem[i_b_addr];
                    end
                end
            end

            assign a_data_word[gi*LANE_WIDTH +: LANE_WIDTH] = a_lane_reg;
            assign b_data_word[gi*LANE_WIDTH +: LANE_WIDTH] = b_lane_reg;
        end
    endgenerate

    assign o_a_data  = a_data_word;
    assign o_b_data  = b_data_word;
    assign o_a_valid = a_valid_reg;
    assign o_b_valid = b_valid_reg;
    assign o_busy    = busy_reg;

endmodule

// File: tb/tb_bram_be.sv
`timescale 1ns/1ps
// Testbench for bram_be. Three instances (RDW_MODE 0/1/2) share the same
// stimulus. A reference memory predicts each response. The expected
// response is queued together with the cycle it is due and compared at the
// negative edge.
module tb_bram_be;

    localparam int AW = 4;
    localparam int NM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_write = 1'b0, b_req = 1'b0;
    logic [3:0]  a_be = '0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0;

    logic [31:0] a_data_o [NM];
    logic [31:0] b_data_o [NM];
    logic        a_valid_o [NM];
    logic        b_valid_o [NM];
    logic        busy_o [NM];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NM; gi++) begin : g_dut
            bram_be #(
                .LANES(4), .LANE_WIDTH(8), .ADDR_WIDTH(AW),
                .RDW_MODE(gi), .CLEAR_ON_RESET(1)
            ) dut (
                .i_clk(clk), .i_rst_n(rst_n),
                .i_a_req(a_req), .i_a_write(a_write), .i_a_be(a_be),
                .i_a_addr(a_addr), .i_a_data(a_wdata),
                .o_a_data(a_data_o[gi]), .o_a_valid(a_valid_o[gi]),
                .i_b_req(b_req), .i_b_addr(b_addr),
                .o_b_data(b_data_o[gi]), .o_b_valid(b_valid_o[gi]),
                .o_busy(busy_o[gi])
            );
        end
    endgenerate

    typedef struct packed {
        logic [31:0]      due;
        logic [2:0][31:0] d;
    } a_exp_t;
    typedef struct packed {
        logic [31:0] due;
        logic [31:0] d;
    } b_exp_t;

    a_exp_t      qa[$];
    b_exp_t      qb[$];
    logic [31:0] mem_m [16];
    logic [31:0] prev_a [NM];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[k*8 +: 8] = nw[k*8 +: 8];
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Response monitor: each valid is checked every cycle. Data is checked
    // when a response is due.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            logic exp_a, exp_b;
            a_exp_t ea;
            b_exp_t eb;
            exp_a = (qa.size() > 0) && (qa[0].due == 32'(cyc));
            exp_b = (qb.size() > 0) && (qb[0].due == 32'(cyc));
            for (int m = 0; m < NM; m++) begin
                check($sformatf("a_valid_m%0d", m), 32'(a_valid_o[m]), 32'(exp_a));
                check($sformatf("b_valid_m%0d", m), 32'(b_valid_o[m]), 32'(exp_b));
            end
            if (exp_a) begin
                ea = qa.pop_front();
                $display("[%0d] A rsp want %h/%h/%h", cyc, ea.d[0], ea.d[1], ea.d[2]);
                for (int m = 0; m < NM; m++) begin
                    check($sformatf("a_data_m%0d", m), a_data_o[m], ea.d[m]);
                end
            end
            if (exp_b) begin
                eb = qb.pop_front();
                $display("[%0d] B rsp want %h", cyc, eb.d);
                for (int m = 0; m < NM; m++) begin
                    check($sformatf("b_data_m%0d", m), b_data_o[m], eb.d);
                end
            end
        end
    end

    // One cycle of accepted stimulus. The B expectation is taken before the
    // A write, so a same-cycle collision returns the old word.
    task automatic step(input logic ar, input logic aw, input logic [3:0] be,
                        input logic [AW-1:0] aa, input logic [31:0] ad,
                        input logic br, input logic [AW-1:0] ba);
        a_exp_t ea;
        b_exp_t eb;
        logic [31:0] old;
        a_req = ar; a_write = aw; a_be = be; a_addr = aa; a_wdata = ad;
        b_req = br; b_addr = ba;
        if (br) begin
            eb.due = 32'(cyc + 1);
            eb.d   = mem_m[ba];
            qb.push_back(eb);
        end
        if (ar) begin
            old = mem_m[aa];
            if (aw) begin
                prev_a[1] = old;
                prev_a[2] = merge(old, ad, be);
                mem_m[aa] = prev_a[2];
            end else begin
                for (int m = 0; m < NM; m++) prev_a[m] = old;
            end
            ea.due = 32'(cyc + 1);
            for (int m = 0; m < NM; m++) ea.d[m] = prev_a[m];
            qa.push_back(ea);
        end
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic do_reset(input int n);
        a_req = 1'b0; b_req = 1'b0;
        rst_n = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
        for (int m = 0; m < NM; m++) begin
            check($sformatf("rst_a_data_m%0d", m), a_data_o[m], 32'h0);
            check($sformatf("rst_b_data_m%0d", m), b_data_o[m], 32'h0);
            check($sformatf("rst_busy_m%0d", m), 32'(busy_o[m]), 32'h1);
            prev_a[m] = '0;
        end
        rst_n = 1'b1;
    endtask

    // Runs `edges` clear cycles. Every cycle also carries garbage requests,
    // and these must be dropped.
    task automatic run_clear(input int edges);
        for (int k = 1; k <= edges; k++) begin
            a_req = 1'b1; a_write = 1'b1; a_be = 4'hF;
            a_addr = 4'(k); a_wdata = 32'hFFFF_FFFF;
            b_req = 1'b1; b_addr = 4'(k);
            @(posedge clk); #1;
            for (int m = 0; m < NM; m++) begin
                check($sformatf("busy_e%0d_m%0d", k, m), 32'(busy_o[m]), 32'(k < 16));
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        if (edges == 16) begin
            for (int i = 0; i < 16; i++) mem_m[i] = '0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        do_reset(3);
        mon_en = 1'b1;
        run_clear(16);

        // Fill memory with garbage, then reset and confirm the clear
        for (int i = 0; i < 16; i++) step(1, 1, 4'hF, 4'(i), 32'hA5A5_0000 | 32'(i), 0, '0);
        step(0, 0, '0, '0, '0, 1, 4'd3);
        step(1, 0, '0, 4'd4, '0, 0, '0);
        do_reset(3);
        run_clear(16);
        for (int i = 0; i < 16; i++) step(0, 0, '0, '0, '0, 1, 4'(i));

        // Byte-enable merge
        step(1, 1, 4'hF, 4'd5, 32'h1122_3344, 0, '0);
        step(1, 1, 4'h5, 4'd5, 32'hAABB_CCDD, 0, '0);
        step(1, 0, 4'h0, 4'd5, 32'h0, 0, '0);
        step(1, 1, 4'h0, 4'd5, 32'hFFFF_FFFF, 0, '0);
        step(1, 0, 4'h0, 4'd5, 32'h0, 0, '0);

        // Read-during-write modes
        step(1, 1, 4'hF, 4'd2, 32'h0000_FFFF, 0, '0);
        step(1, 1, 4'hF, 4'd9, 32'hCAFE_BABE, 0, '0);
        step(1, 0, 4'h0, 4'd9, 32'h0, 0, '0);
        step(1, 1, 4'hC, 4'd2, 32'h1234_5678, 0, '0);
        step(1, 0, 4'h0, 4'd2, 32'h0, 0, '0);

        // Cross-port collision
        step(1, 1, 4'hF, 4'd7, 32'h0000_0001, 0, '0);
        step(1, 1, 4'hF, 4'd7, 32'hDEAD_BEEF, 1, 4'd7);
        step(0, 0, '0, '0, '0, 1, 4'd7);

        // Back-to-back throughput
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 4'hF, 4'(i + 8), 32'h5000_0000 + 32'(i), 1, 4'(i));
        end
        step(0, 0, '0, '0, '0, 0, '0);

        // Reset in the middle of a clear
        for (int i = 0; i < 16; i++) step(1, 1, 4'hF, 4'(i), 32'h3C3C_0000 | 32'(i), 0, '0);
        step(1, 0, '0, 4'd6, '0, 1, 4'd6);
        step(0, 0, '0, '0, '0, 0, '0);
        do_reset(2);
        run_clear(9);
        do_reset(1);
        run_clear(16);
        for (int i = 0; i < 16; i++) step(0, 0, '0, '0, '0, 1, 4'(i));
        step(1, 0, '0, 4'd5, '0, 0, '0);

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("qa_drained", 32'(qa.size()), 32'h0);
        check("qb_drained", 32'(qb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
